dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory.
// Round-robin or fixed priority; each transaction takes IDLE -> ACCESS -> RESP.
module dmem_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state;
    logic              r_last;
    logic              r_win;
    logic              r_we;
    logic              r_gnt0, r_gnt1, r_ack0, r_ack1;
    logic              r_mem_we;
    logic              r_busy;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;
    logic              w_win;

    // Winner index: 1 selects port 1.
    always_comb begin
        w_win = 1'b0;
        if (p0_req && p1_req)
            w_win = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
        else
            w_win = ~p0_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_win       <= 1'b0;
            r_we        <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        r_state     <= ACCESS;
                        r_busy      <= 1'b1;
                        r_win       <= w_win;
                        r_last      <= w_win;
                        r_we        <= w_win ? p1_we : p0_we;
                        r_mem_we    <= w_win ? p1_we : p0_we;
                        r_mem_addr  <= w_win ? p1_addr : p0_addr;
                        r_mem_wdata <= w_win ? p1_wdata : p0_wdata;
                        r_gnt0      <= ~w_win;
                        r_gnt1      <= w_win;
                    end
                end
                ACCESS: r_state <= RESP;
                RESP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ack0  <= ~r_win;
                    r_ack1  <= r_win;
                    if (!r_we) begin
                        if (r_win) r_rdata1 <= mem_rdata;
                        else       r_rdata0 <= mem_rdata;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Write strobe is masked by rst so an aborted ACCESS never reaches memory.
    assign mem_we    = r_mem_we & ~rst;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign p0_gnt    = r_gnt0;
    assign p1_gnt    = r_gnt1;
    assign p0_ack    = r_ack0;
    assign p1_ack    = r_ack1;
    assign p0_rdata  = r_rdata0;
    assign p1_rdata  = r_rdata1;
    assign busy      = r_busy;

endmodule
